// File: rtl/register_file.sv
// 32 x 32-bit RISC-V integer register file.
// Registered dual read ports with same-cycle write bypass and stall hold.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        regf_we,
    input  logic [4:0]  rd_s,
    input  logic [31:0] rd_v,
    input  logic        rd_en,
    input  logic [4:0]  rs1_s,
    input  logic [4:0]  rs2_s,
    output logic [31:0] rs1_v,
    output logic [31:0] rs2_v
);

    logic [31:0] regs_q [32];
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        wr_en;

    assign wr_en = regf_we && (rd_s != 5'd0);

    // x0 wins over bypass, bypass wins over stored value
    function automatic logic [31:0] read_port(
        input logic [4:0]  idx,
        input logic        we,
        input logic [4:0]  widx,
        input logic [31:0] wdat,
        input logic [31:0] stored
    );
        logic [31:0] val;
        val = stored;
        if (idx == 5'd0) begin
            val = 32'd0;
        end else if (we && (widx == idx)) begin
            val = wdat;
        end
        return val;
    endfunction

    always_comb begin
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (rd_en) begin
            rs1_d = read_port(rs1_s, regf_we, rd_s, rd_v, regs_q[rs1_s]);
            rs2_d = read_port(rs2_s, regf_we, rd_s, rd_v, regs_q[rs2_s]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            rs1_q <= 32'd0;
            rs2_q <= 32'd0;
        end else begin
            if (wr_en) begin
                regs_q[rd_s] <= rd_v;
            end
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
        end
    end

    assign rs1_v = rs1_q;
    assign rs2_v = rs2_q;

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed vector table plus
// randomized traffic against a storage-level reference model.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        regf_we;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        rd_en;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;

    always #5 clk = ~clk;

    register_file dut (
        .clk     (clk),
        .rst     (rst),
        .regf_we (regf_we),
        .rd_s    (rd_s),
        .rd_v    (rd_v),
        .rd_en   (rd_en),
        .rs1_s   (rs1_s),
        .rs2_s   (rs2_s),
        .rs1_v   (rs1_v),
        .rs2_v   (rs2_v)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] v;
        logic        en;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: architectural register contents and visible outputs
    logic [31:0] mem [32];
    logic [31:0] m1, m2;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: apply the write to storage first, then a read sees the
    // post-write architectural value (x0 is always zero).
    task automatic model_step(input logic r, input logic we,
                              input logic [4:0] rd, input logic [31:0] v,
                              input logic en, input logic [4:0] s1,
                              input logic [4:0] s2);
        if (r) begin
            foreach (mem[i]) mem[i] = 32'd0;
            m1 = 32'd0;
            m2 = 32'd0;
        end else begin
            if (we && rd != 0) mem[rd] = v;
            if (en) begin
                m1 = (s1 == 0) ? 32'd0 : mem[s1];
                m2 = (s2 == 0) ? 32'd0 : mem[s2];
            end
        end
    endtask

    task automatic apply(input logic r, input logic we,
                         input logic [4:0] rd, input logic [31:0] v,
                         input logic en, input logic [4:0] s1,
                         input logic [4:0] s2);
        rst = r; regf_we = we; rd_s = rd; rd_v = v;
        rd_en = en; rs1_s = s1; rs2_s = s2;
        @(posedge clk);
        #1;
        model_step(r, we, rd, v, en, s1, s2);
    endtask

    vec_t tbl [16];

    initial begin
        rst = 1'b1; regf_we = 1'b0; rd_s = '0; rd_v = '0;
        rd_en = 1'b0; rs1_s = '0; rs2_s = '0;
        foreach (mem[i]) mem[i] = 32'd0;
        m1 = 32'd0;
        m2 = 32'd0;

        //          rst we  rd  v             en  s1  s2  e1            e2
        tbl[0]  = '{1, 0,  0, 32'h0,        0,  0,  0, 32'h0,        32'h0};
        tbl[1]  = '{0, 0,  0, 32'h0,        1,  5, 31, 32'h0,        32'h0};
        tbl[2]  = '{0, 1,  7, 32'hDEADBEEF, 1,  5, 31, 32'h0,        32'h0};
        tbl[3]  = '{0, 0,  0, 32'h0,        1,  7,  0, 32'hDEADBEEF, 32'h0};
        tbl[4]  = '{0, 1,  3, 32'h12345678, 1,  3,  3, 32'h12345678, 32'h12345678};
        tbl[5]  = '{0, 1,  0, 32'hFFFFFFFF, 1,  0,  3, 32'h0,        32'h12345678};
        tbl[6]  = '{0, 0,  0, 32'h0,        1,  0,  7, 32'h0,        32'hDEADBEEF};
        tbl[7]  = '{0, 1,  4, 32'h11,       1,  0,  0, 32'h0,        32'h0};
        tbl[8]  = '{0, 0,  0, 32'h0,        1,  4,  7, 32'h11,       32'hDEADBEEF};
        tbl[9]  = '{0, 1,  4, 32'h22,       0,  4,  4, 32'h11,       32'hDEADBEEF};
        tbl[10] = '{0, 0,  0, 32'h0,        1,  4,  3, 32'h22,       32'h12345678};
        tbl[11] = '{1, 1,  9, 32'hAA,       1,  9,  4, 32'h0,        32'h0};
        tbl[12] = '{0, 0,  0, 32'h0,        1,  9,  4, 32'h0,        32'h0};
        tbl[13] = '{0, 0,  0, 32'h0,        1,  7,  3, 32'h0,        32'h0};
        tbl[14] = '{0, 1,  2, 32'h5,        1,  2,  0, 32'h5,        32'h0};
        tbl[15] = '{1, 0,  0, 32'h0,        0,  2,  2, 32'h0,        32'h0};

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].rst, tbl[i].we, tbl[i].rd, tbl[i].v,
                  tbl[i].en, tbl[i].s1, tbl[i].s2);
            chk($sformatf("vec%0d rs1_v", i), rs1_v, tbl[i].e1);
            chk($sformatf("vec%0d rs2_v", i), rs2_v, tbl[i].e2);
        end

        // Hand sequence: two stall cycles with writes, then resume
        apply(0, 1, 6, 32'hCAFE0001, 1, 6, 6);
        chk("seq bypass rs1", rs1_v, 32'hCAFE0001);
        chk("seq bypass rs2", rs2_v, 32'hCAFE0001);
        apply(0, 1, 6, 32'hCAFE0002, 0, 6, 1);
        apply(0, 1, 1, 32'hCAFE0003, 0, 6, 1);
        chk("seq hold rs1", rs1_v, 32'hCAFE0001);
        chk("seq hold rs2", rs2_v, 32'hCAFE0001);
        apply(0, 0, 0, 32'h0, 1, 6, 1);
        chk("seq resume rs1", rs1_v, 32'hCAFE0002);
        chk("seq resume rs2", rs2_v, 32'hCAFE0003);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic        r, we, en;
            logic [4:0]  rd, s1, s2;
            logic [31:0] v;
            r  = ($urandom_range(0, 59) == 0);
            we = ($urandom_range(0, 9) < 7);
            en = ($urandom_range(0, 3) != 0);
            rd = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            s1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            s2 = ($urandom_range(0, 4) == 0) ? s1 : 5'($urandom_range(0, 7));
            v  = $urandom;
            apply(r, we, rd, v, en, s1, s2);
            chk($sformatf("rnd%0d rs1_v", n), rs1_v, m1);
            chk($sformatf("rnd%0d rs2_v", n), rs2_v, m2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port regf_we  input  1  write enable from the write-back stage.
REQ-005 Port rd_s  input  5  destination register index from the write-back stage.
REQ-006 Port rd_v  input  32  write data from the write-back stage.
REQ-007 Port rd_en  input  1  decode-side read enable; low means stall/hold.
REQ-008 Port rs1_s  input  5  source register 1 index.
REQ-009 Port rs2_s  input  5  source register 2 index.
REQ-010 Port rs1_v  output  32  registered read data, port 1.
REQ-011 Port rs2_v  output  32  registered read data, port 2.

Function
REQ-012 Storage SHALL be 32 entries x 32 bits (x0..x31).
REQ-013 Write: at a rising edge with regf_we=1 and rd_s!=0 and rst=0, entry[rd_s] SHALL take rd_v.
REQ-014 Writes SHALL be ignored when rd_s=0; x0 SHALL always read 0.
REQ-015 Reads SHALL be synchronous with 1-cycle latency: an index presented at edge N SHALL appear on rsX_v after edge N.
REQ-016 At an edge with rd_en=1, rsX_v SHALL load 0 if rsX_s=0.
REQ-017 Otherwise, at an edge with rd_en=1, rsX_v SHALL load rd_v if regf_we=1 and rd_s=rsX_s (same-cycle write bypass).
REQ-018 Otherwise, at an edge with rd_en=1, rsX_v SHALL load entry[rsX_s] as held before that edge.
REQ-019 At an edge with rd_en=0, rs1_v and rs2_v SHALL hold their values.
REQ-020 During such a hold, writes SHALL still commit to storage; held outputs SHALL NOT update even if their register is written.
REQ-021 rs1_s and rs2_s MAY be equal; both ports SHALL then return identical data, including bypassed data.
REQ-022 There SHALL be no combinational path from any input to rs1_v or rs2_v.
REQ-023 With regf_we=1, rd_s=0 and rsX_s=0, rsX_v SHALL load 0 (no bypass to x0).

Reset
REQ-024 At an edge with rst=1, all 32 entries, rs1_v and rs2_v SHALL become 0.
REQ-025 Reset SHALL take priority over any write or read in the same cycle.
REQ-026 The first edge after rst deasserts SHALL behave as a normal cycle.

Verification
REQ-027 Scenario: reset, then read x5/x31 with rd_en=1 -> rs1_v=0, rs2_v=0 one cycle later.
REQ-028 Scenario: write x7=0xDEADBEEF; next cycle read rs1_s=7 -> rs1_v=0xDEADBEEF after the following edge.
REQ-029 Scenario: same edge, write x3=0x12345678 and read rs1_s=rs2_s=3 -> both outputs=0x12345678 (bypass).
REQ-030 Scenario: write x0=0xFFFFFFFF with read rs1_s=0 in the same cycle, then again next cycle -> rs1_v=0 both times.
REQ-031 Scenario: rs1_v showing x4=0x11; rd_en=0 while x4 is written 0x22 -> rs1_v stays 0x11; then rd_en=1 -> rs1_v=0x22.
REQ-032 Scenario: rst=1 on the same edge as a write of x9=0xAA -> x9 reads 0 afterwards, and outputs=0 after the reset edge.
